// File: rtl/countdown_timer_n.sv
// countdown_timer_n
// BCD mm:ss countdown timer. Keypad digits shift in from the right. Entries
// with seconds above 59 are normalised for one cycle before running. The count
// then decrements once per 1 Hz tick while running.
// Optional feature: define COUNTER_BLANK_EN to build leading-zero blanking.
// When it is not defined, blank is tied low.
// Ports:
//   clk      - system clock, rising edge
//   clrn     - asynchronous active-low reset
//   data     - keypad BCD digit; values above 9 are ignored
//   loadn    - active-low digit strobe; one digit per low cycle
//   enable   - run (1) / pause-stop (0) level
//   tick     - single-cycle 1 Hz decrement strobe
//   sec_ones - seconds units digit (registered)
//   sec_tens - seconds tens digit (registered)
//   mins     - minute digits, digit k at [4k+3:4k], k=0 is units (registered)
//   blank    - per-digit leading-zero blank flags (combinational)
//   zero     - all digits are 0 (combinational)
//   running  - state is RUN (registered)
//   done     - one-cycle pulse when a running count reaches 0 (registered)
module countdown_timer_n #(
  parameter int MIN_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic [3:0]              data,
  input  logic                    loadn,
  input  logic                    enable,
  input  logic                    tick,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic [MIN_DIGITS+1:0]   blank,
  output logic                    zero,
  output logic                    running,
  output logic                    done
);

  localparam int ND = MIN_DIGITS + 2;  // total digit count
  localparam int CW = 4 * ND;          // packed count width
  localparam int MW = 4 * MIN_DIGITS;  // minutes width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_NORM  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;  // {mins, sec_tens, sec_ones}
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic            digit_ok_s;
  logic            shift_s;
  logic            dec_s;
  logic [CW-1:0]   count_dec_s;

  // One-second BCD decrement. Digit 1 (seconds tens) wraps to 5; all others wrap to 9.
  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] c);
    logic [CW-1:0] r;
    logic          borrow;
    r      = c;
    borrow = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (borrow) begin
        if (c[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
          borrow      = 1'b1;
        end else begin
          r[4*i +: 4] = c[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*i +: 4] = c[4*i +: 4];
      end
    end
    return r;
  endfunction

  // BCD increment of the minute digits; the caller guards the all-9 case.
  function automatic logic [MW-1:0] bcd_inc(input logic [MW-1:0] m);
    logic [MW-1:0] r;
    logic          carry;
    r     = m;
    carry = 1'b1;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (carry) begin
        if (m[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*i +: 4] = m[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*i +: 4] = m[4*i +: 4];
      end
    end
    return r;
  endfunction

  assign zero        = (count_q == {CW{1'b0}});
  assign digit_ok_s  = (data <= 4'd9);
  assign shift_s     = !loadn && digit_ok_s &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Pause wins over a coincident tick.
  assign dec_s       = (state_q == ST_RUN) && enable && tick && !zero;
  assign count_dec_s = bcd_dec(count_q);

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // A strobe takes priority; enable is looked at again next cycle.
        if (!loadn) begin
          state_d = ST_IDLE;
        end else if (enable && !zero) begin
          state_d = ST_NORM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_NORM: state_d = ST_RUN;
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_PAUSE;
        end else if (dec_s && (count_dec_s == {CW{1'b0}})) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (shift_s || !enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: running follows the next state, and done marks entry into DONE.
  always_comb begin
    running_d = (state_d == ST_RUN);
    if ((state_q == ST_RUN) && (state_d == ST_DONE)) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // Digit datapath: shift-in, normalisation and decrement.
  always_comb begin
    count_d = count_q;
    if (shift_s) begin
      count_d[3:0] = data;
      for (int i = 1; i < ND; i++) begin
        count_d[4*i +: 4] = count_q[4*(i-1) +: 4];
      end
    end else if ((state_q == ST_NORM) && (count_q[7:4] > 4'd5)) begin
      if (count_q[CW-1:8] == {MIN_DIGITS{4'd9}}) begin
        count_d = {{MIN_DIGITS{4'd9}}, 4'd5, 4'd9};
      end else begin
        count_d = {bcd_inc(count_q[CW-1:8]), count_q[7:4] - 4'd6, count_q[3:0]};
      end
    end else if (dec_s) begin
      count_d = count_dec_s;
    end else begin
      count_d = count_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_q   <= {CW{1'b0}};
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign sec_ones = count_q[3:0];
  assign sec_tens = count_q[7:4];
  assign mins     = count_q[CW-1:8];
  assign running  = running_q;
  assign done     = done_q;

`ifdef COUNTER_BLANK_EN
  logic [ND-1:0] blank_s;

  // Leading-zero blanking, scanned from the top digit down. The units digit
  // stays lit except at zero in IDLE, so DONE still shows "0".
  always_comb begin
    logic hi_zero;
    hi_zero = 1'b1;
    blank_s = {ND{1'b0}};
    for (int i = ND - 1; i >= 0; i--) begin
      hi_zero    = hi_zero && (count_q[4*i +: 4] == 4'd0);
      blank_s[i] = hi_zero;
    end
    blank_s[0] = zero && (state_q == ST_IDLE);
  end

  assign blank = blank_s;
`else
  assign blank = {(MIN_DIGITS+2){1'b0}};
`endif

endmodule

// File: tb/tb_countdown_timer_n.sv
module tb_countdown_timer_n;

  logic       clk;
  logic       clrn;
  logic [3:0] data;
  logic       loadn;
  logic       enable;
  logic       tick;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [7:0] mins;
  logic [3:0] blank;
  logic       zero;
  logic       running;
  logic       done;

  int checks_cnt   = 0;
  int failures_cnt = 0;
  int done_pulses  = 0;

  countdown_timer_n #(.MIN_DIGITS(2)) dut (
    .clk(clk), .clrn(clrn), .data(data), .loadn(loadn), .enable(enable),
    .tick(tick), .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins),
    .blank(blank), .zero(zero), .running(running), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      failures_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    data  = d;
    loadn = 1'b0;
    step();
    loadn = 1'b1;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    #2;
    clrn = 1'b1;
    step();
  endtask

  // Returns {mins, sec_tens, sec_ones} for compact comparisons.
  function automatic logic [31:0] cnt();
    return {16'h0, mins, sec_tens, sec_ones};
  endfunction

  initial begin
    clrn = 1'b0; data = 4'd0; loadn = 1'b1; enable = 1'b0; tick = 1'b0;
    #12;
    check_eq("rst_count", cnt(), 32'h0000);
    check_eq("rst_zero", {31'b0, zero}, 32'd1);
    check_eq("rst_running", {31'b0, running}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    clrn = 1'b1;
    step();

    // Keys 1,9,0 -> 01:90, normalised to 02:30.
    key(4'd1); key(4'd9); key(4'd0);
    check_eq("load_190", cnt(), 32'h0190);
    enable = 1'b1;
    step();
    check_eq("norm_not_running", {31'b0, running}, 32'd0);
    step();
    check_eq("norm_result", cnt(), 32'h0230);
    check_eq("run_running", {31'b0, running}, 32'd1);

    // 150 ticks down to zero.
    for (int i = 0; i < 150; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (done) done_pulses++;
      if (i == 0) check_eq("first_tick", cnt(), 32'h0229);
      if (i == 149) check_eq("done_at_zero", {31'b0, done}, 32'd1);
      step();
      if (done) done_pulses++;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) done_pulses++;
    end
    check_eq("done_pulses", done_pulses, 32'd1);
    check_eq("end_zero", {31'b0, zero}, 32'd1);
    check_eq("end_running", {31'b0, running}, 32'd0);
`ifdef COUNTER_BLANK_EN
    check_eq("blank_done", {28'b0, blank}, 32'hE);
`else
    check_eq("blank_done", {28'b0, blank}, 32'h0);
`endif
    enable = 1'b0;
    step();
`ifdef COUNTER_BLANK_EN
    check_eq("blank_idle0", {28'b0, blank}, 32'hF);
`else
    check_eq("blank_idle0", {28'b0, blank}, 32'h0);
`endif

    // Asynchronous reset in the middle of a countdown from 1:23.
    key(4'd1); key(4'd2); key(4'd3);
    enable = 1'b1;
    step(); step();
    tick = 1'b1; step(); tick = 1'b0;
    check_eq("tick_123", cnt(), 32'h0122);
    #2;
    clrn = 1'b0;
    #1;
    check_eq("midrun_rst_count", cnt(), 32'h0000);
    check_eq("midrun_rst_zero", {31'b0, zero}, 32'd1);
    check_eq("midrun_rst_running", {31'b0, running}, 32'd0);
    check_eq("midrun_rst_done", {31'b0, done}, 32'd0);
    enable = 1'b0;
    clrn = 1'b1;
    step();

    // 10:00 -> 09:59, then pause wins over a coincident tick.
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    enable = 1'b1;
    step(); step();
    tick = 1'b1; step(); tick = 1'b0;
    check_eq("borrow_1000", cnt(), 32'h0959);
    enable = 1'b0; tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq("pause_wins_count", cnt(), 32'h0959);
    check_eq("pause_wins_running", {31'b0, running}, 32'd0);
    key(4'd5);
    check_eq("load_in_pause", cnt(), 32'h0959);
    enable = 1'b1;
    step();
    check_eq("resume_running", {31'b0, running}, 32'd1);
    key(4'd5);
    check_eq("load_in_run", cnt(), 32'h0959);
    do_reset();

    // Saturation: 99:99 -> 99:59.
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    enable = 1'b1;
    step(); step();
    check_eq("saturate", cnt(), 32'h9959);
    enable = 1'b0;
    do_reset();

    // Five keys: the oldest digit falls off the top.
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    check_eq("five_keys", cnt(), 32'h2345);
    key(4'hC);
    check_eq("invalid_digit", cnt(), 32'h2345);
    do_reset();

    // Enable with a zero count stays in IDLE, and keys are still accepted.
    enable = 1'b1;
    step(); step(); step();
    check_eq("zero_enable_running", {31'b0, running}, 32'd0);
    enable = 1'b0;
    key(4'd5);
    check_eq("zero_enable_idle_key", cnt(), 32'h0005);
`ifdef COUNTER_BLANK_EN
    check_eq("blank_0005", {28'b0, blank}, 32'hE);
`else
    check_eq("blank_0005", {28'b0, blank}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule
